// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT stage sequencer: state codes, defaults,
// stage indices and a small state-classification helper.
package sift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BLUR     = 3'd1,
    ST_DOG      = 3'd2,
    ST_DETECT   = 3'd3,
    ST_NEXT_OCT = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  localparam int unsigned DEF_NUM_SCALES  = 4;
  localparam int unsigned DEF_NUM_OCTAVES = 1;
  localparam int unsigned DEF_TIMEOUT     = 1000000;
  localparam int unsigned DEF_OCT_W       = 3;

  localparam int unsigned STG_BLUR   = 0;
  localparam int unsigned STG_DOG    = 1;
  localparam int unsigned STG_DETECT = 2;
  localparam int unsigned NUM_STAGES = 3;

  // Waiting states are the ones guarded by the watchdog.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_BLUR) || (s == ST_DOG) || (s == ST_DETECT);
  endfunction

endpackage

// File: rtl/sift_stage_ctrl_if.sv
// Host/stage-engine handshake bundle of the SIFT stage sequencer.
// master = host and engines, slave = sequencer.
interface sift_stage_ctrl_if #(
  parameter int unsigned NUM_SCALES = 4,
  parameter int unsigned OCT_W      = 3
);
  logic                  start;
  logic                  abort;
  logic [NUM_SCALES-1:0] scale_done;
  logic                  dog_done;
  logic                  kp_done;
  logic [NUM_SCALES-1:0] scale_start;
  logic                  dog_start;
  logic                  kp_start;
  logic [OCT_W-1:0]      octave;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [2:0]            state;

  modport master (
    output start, abort, scale_done, dog_done, kp_done,
    input  scale_start, dog_start, kp_start, octave, busy, done, err, state
  );

  modport slave (
    input  start, abort, scale_done, dog_done, kp_done,
    output scale_start, dog_start, kp_start, octave, busy, done, err, state
  );
endinterface

// File: rtl/sift_done_collector.sv
// Aggregates N one-cycle done pulses into sticky flags; all_done is
// combinational so a final pulse completes the set in its own cycle.
module sift_done_collector #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] pulse,
  output logic         all_done
);
  logic [N-1:0] r_flags;
  logic [N-1:0] w_merged;

  // Flags and same-cycle pulses merged for the completion test.
  always_comb begin
    w_merged = r_flags | pulse;
  end

  assign all_done = &w_merged;

  // Sticky flag register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (clear) begin
      r_flags <= '0;
    end else begin
      r_flags <= w_merged;
    end
  end
endmodule

// File: rtl/sift_stage_ctrl.sv
// Multi-octave SIFT stage sequencer: BLUR bank -> DoG -> keypoint detect per
// octave, with per-stage watchdog, abort and progress reporting.
module sift_stage_ctrl
  import sift_pkg::*;
#(
  parameter int unsigned NUM_SCALES  = DEF_NUM_SCALES,
  parameter int unsigned NUM_OCTAVES = DEF_NUM_OCTAVES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned OCT_W       = DEF_OCT_W
) (
  input  logic              clk,
  input  logic              rst_n,   // active-high despite the name
  sift_stage_ctrl_if.slave  bus
);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  state_t                r_state;
  state_t                w_next;
  logic [WD_W-1:0]       r_wd;
  logic [OCT_W-1:0]      r_octave;
  logic                  r_err;
  logic                  w_timeout;
  logic                  w_wd_expired;
  logic                  w_run_start;
  logic                  w_clear;
  logic                  w_all_scales;
  logic                  w_last_oct;
  logic [NUM_SCALES-1:0] w_scale_pulse;

  // Qualifiers derived from the registered state.
  always_comb begin
    w_run_start   = (r_state == ST_IDLE) && bus.start;
    w_clear       = w_run_start || (r_state == ST_NEXT_OCT);
    w_scale_pulse = bus.scale_done & {NUM_SCALES{r_state == ST_BLUR}};
    w_wd_expired  = is_wait_state(r_state) && (r_wd == WD_W'(TIMEOUT - 1));
    w_last_oct    = (r_octave == OCT_W'(NUM_OCTAVES - 1));
  end

  sift_done_collector #(.N(NUM_SCALES)) u_scale_done (
    .clk      (clk),
    .rst      (rst_n),
    .clear    (w_clear),
    .pulse    (w_scale_pulse),
    .all_done (w_all_scales)
  );

  // Next-state decode; a stage completion beats the watchdog, abort beats both.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = ST_BLUR;
      end
      ST_BLUR: begin
        if (w_all_scales) begin
          w_next = ST_DOG;
        end else if (w_wd_expired) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_DOG: begin
        if (bus.dog_done) begin
          w_next = ST_DETECT;
        end else if (w_wd_expired) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_DETECT: begin
        if (bus.kp_done) begin
          w_next = w_last_oct ? ST_FINISH : ST_NEXT_OCT;
        end else if (w_wd_expired) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_NEXT_OCT: w_next = ST_BLUR;
      ST_FINISH:   w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && bus.abort) begin
      w_next    = ST_IDLE;
      w_timeout = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Watchdog: counts cycles spent in a waiting state, cleared on any change.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wd <= '0;
    end else if ((w_next != r_state) || !is_wait_state(r_state)) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // Octave index: zeroed at run start, advanced when leaving NEXT_OCT.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_octave <= '0;
    end else if (w_run_start) begin
      r_octave <= '0;
    end else if (r_state == ST_NEXT_OCT) begin
      r_octave <= r_octave + OCT_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by a new run.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_err <= 1'b0;
    end else if (w_run_start) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.scale_start = {NUM_SCALES{r_state == ST_BLUR}};
  assign bus.dog_start   = (r_state == ST_DOG);
  assign bus.kp_start    = (r_state == ST_DETECT);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = (r_state == ST_FINISH);
  assign bus.octave      = r_octave;
  assign bus.err         = r_err;
  assign bus.state       = r_state;
endmodule
